spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Parametrised SPI transfer controller FSM for the SPI core, driving shifter, SPDR and SPSR control. Generalises the single-byte master/slave controller: configurable frame width, internal bit counter, multi-frame bursts with the master holding SS low, and SPIF/WCOL status flags. Runs on the system clock `clk`; the baud-rate generator supplies a one-cycle `bit_tick` strobe instead of a separate clock.

Parameters:
- FRAME_W, 8, bits per frame (2..32).
- BURST_MAX, 4, maximum frames per SS assertion in master mode (1..256).
- CNT_W, $clog2(FRAME_W), bit-counter width.
- BCNT_W, $clog2(BURST_MAX+1), burst-length field width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- spe  in  1  SPI enable (SPCR)
- mstr  in  1  master select (SPCR)
- ss_n_in  in  1  external slave select, active low (slave mode)
- bit_tick  in  1  one-clk strobe per bit period from baud generator
- tx_wr  in  1  CPU write to SPDR, one-clk pulse
- burst_len  in  BCNT_W  frames per burst in master mode; 0 treated as 1
- spif_clr  in  1  CPU clear of SPIF/WCOL, one-clk pulse
- ss_n_out  out  1  master-driven slave select
- load_en  out  1  shifter loads from SPDR
- shift_en  out  1  shifter shifts one bit
- capture_en  out  1  shifter writes received frame to SPDR
- bit_cnt  out  CNT_W  current bit index
- idle  out  1  no transfer in progress (to SCK control)
- brg_clr  out  1  baud generator clear
- spif  out  1  transfer-complete flag (sticky)
- wcol  out  1  write-collision flag (sticky)

Behaviour:
- Reset values: state OFF; ss_n_out=1, idle=1, spif=0, wcol=0, bit_cnt=0, frame counter=0. load_en, shift_en and capture_en are 0.
- brg_clr combinational: ~spe | (~mstr & ss_n_in) | (mstr & ss_n_out).
- States: OFF, IDLE, LOAD, RUN, UPDATE. All transitions on posedge clk.
- OFF → IDLE when spe=1.
- Any state → OFF when spe=0. On this transition, spif and wcol keep their values; ss_n_out=1 and counters clear.
- IDLE (idle=1):
  - Master: on tx_wr go to LOAD; ss_n_out drops to 0 on the same edge.
  - Slave: on tx_wr record that a frame is pending. With a frame pending and ss_n_in=0, go to LOAD.
- LOAD: load_en=1 for exactly one clk, bit_cnt=0, then go to RUN.
- RUN (shift_en=bit_tick):
  - Each bit_tick increments bit_cnt.
  - When bit_tick occurs with bit_cnt=FRAME_W-1, go to UPDATE.
  - Slave only: ss_n_in rising in RUN aborts to IDLE. No capture, no SPIF.
- UPDATE: capture_en=1 for one clk, spif set, frame counter increments.
  - Master with frame counter < effective burst_len: go to LOAD if a tx_wr arrived since the last LOAD. Otherwise wait in UPDATE-hold (still UPDATE, capture_en=0) with ss_n_out=0 until tx_wr.
  - Master with burst complete: ss_n_out=1, frame counter=0, go to IDLE.
  - Slave: go to IDLE.
- Latency: master tx_wr in IDLE → load_en 1 clk later → first shift on the next bit_tick. Frame end → capture_en in the clk after the final tick.
- Flags:
  - spif sets in UPDATE and clears on spif_clr.
  - wcol sets when tx_wr occurs in LOAD or RUN; the write is ignored for transfer control. Clears on spif_clr.
  - Set wins over a simultaneous clr.
- bit_tick outside RUN is ignored.
- mstr change outside OFF/IDLE forces OFF (abort).
- Async reset mid-transfer returns immediately to the reset values.

Optional Feature:
SPI_MODF_DETECT_EN.
- With it: adds output `modf` (1 bit, reset 0).
  - In master mode (mstr=1, spe=1), ss_n_in=0 for one clk sets modf.
  - modf forces state OFF and ss_n_out=1, and holds state OFF while modf=1 (overrides spe).
  - spif_clr clears modf.
- Without it: no `modf` port; ss_n_in is ignored when mstr=1.

Test Plan:
- FRAME_W=8, master, burst_len=1, tx_wr, 8 bit_ticks → load_en 1 clk, bit_cnt 0..7, capture_en 1 clk, spif=1, ss_n_out returns to 1, idle=1.
- Master, burst_len=3, tx_wr before each frame end → ss_n_out stays 0 across 24 ticks; capture_en pulses 3 times; ss_n_out=1 after the third.
- Master, burst_len=2, no second tx_wr → FSM holds after frame 1 with ss_n_out=0; tx_wr 50 clks later → second frame completes.
- tx_wr at tick 4 of RUN → wcol=1, frame unaffected; spif_clr with a simultaneous UPDATE → spif stays 1, wcol=0.
- Slave, tx_wr, ss_n_in=0, ss_n_in raised after 3 ticks → return to IDLE, no capture_en, spif=0. rst low mid-RUN → all outputs at reset values the same cycle.
- SPI_MODF_DETECT_EN, master, ss_n_in pulsed low 1 clk in RUN → modf=1, state OFF, ss_n_out=1, brg_clr=1; spif_clr → modf=0, tx_wr restarts a transfer.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: sequences shifter load/shift/capture, master SS and SPIF/WCOL flags.
// Optional build macro SPI_MODF_DETECT_EN adds master mode-fault detection and the modf output.
module spi_xfer_ctrl #(
  parameter int FRAME_W   = 8,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = $clog2(FRAME_W),
  parameter int BCNT_W    = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spe,
  input  logic              mstr,
  input  logic              ss_n_in,
  input  logic              bit_tick,
  input  logic              tx_wr,
  input  logic [BCNT_W-1:0] burst_len,
  input  logic              spif_clr,
  output logic              ss_n_out,
  output logic              load_en,
  output logic              shift_en,
  output logic              capture_en,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              idle,
  output logic              brg_clr,
  output logic              spif,
  output logic              wcol,
  output logic [2:0]        state_dbg
`ifdef SPI_MODF_DETECT_EN
  ,
  output logic              modf
`endif
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam int BL_W = BCNT_W + 1;

  logic [2:0]        state;
  logic [BCNT_W-1:0] frame_cnt;
  logic              pending;
  logic              upd_first;
  logic              mstr_q;
  logic [BL_W-1:0]   eff_len;
  logic [BL_W-1:0]   frame_nxt;
  logic              last_bit;
  logic              burst_more;
  logic              xfer_busy;
  logic              mstr_abort;
  logic              force_off;
  logic              wcol_set;
  logic              spif_set;

  // burst_len of 0 means one frame; values above BURST_MAX saturate.
  always_comb begin
    eff_len = {1'b0, burst_len};
    if (burst_len == '0) begin
      eff_len = BL_W'(1);
    end else if (eff_len > BL_W'(BURST_MAX)) begin
      eff_len = BL_W'(BURST_MAX);
    end
  end

  assign frame_nxt  = {1'b0, frame_cnt} + BL_W'(1);
  assign burst_more = mstr & (frame_nxt < eff_len);
  assign last_bit   = bit_tick & (bit_cnt == CNT_W'(FRAME_W - 1));
  assign xfer_busy  = (state == ST_LOAD) | (state == ST_RUN) | (state == ST_UPDATE);
  assign mstr_abort = xfer_busy & (mstr != mstr_q);

  // A write during a master frame that has a successor in the burst is the
  // next frame's data; any other write while loading or shifting collides.
  assign wcol_set = tx_wr & ((state == ST_LOAD) | ((state == ST_RUN) & ~burst_more));
  assign spif_set = (state == ST_UPDATE) & upd_first;

  assign load_en    = (state == ST_LOAD);
  assign shift_en   = (state == ST_RUN) & bit_tick;
  assign capture_en = (state == ST_UPDATE) & upd_first;
  assign idle       = (state == ST_OFF) | (state == ST_IDLE);
  assign brg_clr    = ~spe | (~mstr & ss_n_in) | (mstr & ss_n_out);
  assign state_dbg  = state;

`ifdef SPI_MODF_DETECT_EN
  logic modf_set;
  assign modf_set  = mstr & spe & ~ss_n_in;
  assign force_off = ~spe | mstr_abort | modf_set | modf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modf <= 1'b0;
    end else begin
      modf <= modf_set | (modf & ~spif_clr);
    end
  end
`else
  assign force_off = ~spe | mstr_abort;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      ss_n_out  <= 1'b1;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      pending   <= 1'b0;
      upd_first <= 1'b0;
      mstr_q    <= 1'b0;
      spif      <= 1'b0;
      wcol      <= 1'b0;
    end else begin
      mstr_q <= mstr;
      spif   <= spif_set | (spif & ~spif_clr);
      wcol   <= wcol_set | (wcol & ~spif_clr);
      if (force_off) begin
        state     <= ST_OFF;
        ss_n_out  <= 1'b1;
        bit_cnt   <= '0;
        frame_cnt <= '0;
        pending   <= 1'b0;
        upd_first <= 1'b0;
      end else begin
        case (state)
          ST_OFF: state <= ST_IDLE;
          ST_IDLE: begin
            if (mstr) begin
              if (tx_wr) begin
                state     <= ST_LOAD;
                ss_n_out  <= 1'b0;
                frame_cnt <= '0;
                pending   <= 1'b0;
              end
            end else begin
              if (tx_wr) pending <= 1'b1;
              if (pending && !ss_n_in) begin
                state   <= ST_LOAD;
                pending <= 1'b0;
              end
            end
          end
          ST_LOAD: begin
            state   <= ST_RUN;
            bit_cnt <= '0;
          end
          ST_RUN: begin
            if (!mstr && ss_n_in) begin
              state   <= ST_IDLE;
              bit_cnt <= '0;
            end else begin
              if (tx_wr && burst_more) pending <= 1'b1;
              if (bit_tick) begin
                if (last_bit) begin
                  state     <= ST_UPDATE;
                  upd_first <= 1'b1;
                  bit_cnt   <= '0;
                end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                end
              end
            end
          end
          ST_UPDATE: begin
            upd_first <= 1'b0;
            if (!mstr) begin
              state     <= ST_IDLE;
              frame_cnt <= '0;
            end else if (upd_first && !burst_more) begin
              state     <= ST_IDLE;
              ss_n_out  <= 1'b1;
              frame_cnt <= '0;
              pending   <= 1'b0;
            end else begin
              // Later cycles here are the burst hold: SS stays low until the next write.
              if (upd_first) frame_cnt <= frame_nxt[BCNT_W-1:0];
              if (pending || tx_wr) begin
                state   <= ST_LOAD;
                pending <= 1'b0;
              end
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl (FRAME_W=8, BURST_MAX=4).
module tb_spi_xfer_ctrl;

  localparam logic [2:0] S_OFF = 3'd0, S_IDLE = 3'd1, S_LOAD = 3'd2, S_RUN = 3'd3, S_UPD = 3'd4;

  logic       clk, rst, spe, mstr, ss_n_in, bit_tick, tx_wr, spif_clr;
  logic [2:0] burst_len;
  logic       ss_n_out, load_en, shift_en, capture_en, idle, brg_clr, spif, wcol;
  logic [2:0] bit_cnt;
  logic [2:0] state_dbg;
`ifdef SPI_MODF_DETECT_EN
  logic       modf;
`endif

  int checks = 0;
  int errors = 0;
  int cap_cnt;
  int ss_hi;

  spi_xfer_ctrl #(.FRAME_W(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .spe(spe), .mstr(mstr), .ss_n_in(ss_n_in),
    .bit_tick(bit_tick), .tx_wr(tx_wr), .burst_len(burst_len), .spif_clr(spif_clr),
    .ss_n_out(ss_n_out), .load_en(load_en), .shift_en(shift_en), .capture_en(capture_en),
    .bit_cnt(bit_cnt), .idle(idle), .brg_clr(brg_clr), .spif(spif), .wcol(wcol),
    .state_dbg(state_dbg)
`ifdef SPI_MODF_DETECT_EN
    , .modf(modf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to the next falling edge and tally what is seen there
  task automatic cyc();
    @(negedge clk);
    if (capture_en) cap_cnt++;
    if (ss_n_out) ss_hi++;
  endtask

  task automatic tick(input logic wr);
    bit_tick = 1'b1;
    tx_wr    = wr;
    cyc();
    bit_tick = 1'b0;
    tx_wr    = 1'b0;
  endtask

  task automatic pulse_clr();
    spif_clr = 1'b1;
    cyc();
    spif_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; spe = 1'b0; mstr = 1'b0; ss_n_in = 1'b1; bit_tick = 1'b0;
    tx_wr = 1'b0; spif_clr = 1'b0; burst_len = 3'd1;
    repeat (2) @(negedge clk);
    checks++; if (state_dbg !== S_OFF) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_OFF); end
    checks++; if (ss_n_out !== 1'b1) begin errors++; $display("FAIL reset_ss_n_out got=%b exp=1", ss_n_out); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if ({spif, wcol} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {spif, wcol}); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if ({load_en, shift_en, capture_en} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {load_en, shift_en, capture_en}); end
    checks++; if (brg_clr !== 1'b1) begin errors++; $display("FAIL reset_brg_clr got=%b exp=1", brg_clr); end
    rst = 1'b1; spe = 1'b1; mstr = 1'b1;
    cyc();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL off_to_idle got=%0d exp=%0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_single();
    burst_len = 3'd1;
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    checks++; if ({load_en, ss_n_out} !== 2'b10) begin errors++; $display("FAIL single_load got=%b exp=10", {load_en, ss_n_out}); end
    cyc();
    checks++; if ({state_dbg, load_en} !== {S_RUN, 1'b0}) begin errors++; $display("FAIL single_run got=%b exp=%b", {state_dbg, load_en}, {S_RUN, 1'b0}); end
    checks++; if (brg_clr !== 1'b0) begin errors++; $display("FAIL single_brg_clr got=%b exp=0", brg_clr); end
    cap_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bit_cnt !== 3'(i)) begin errors++; $display("FAIL single_bit_cnt got=%0d exp=%0d", bit_cnt, i); end
      bit_tick = 1'b1;
      #1;
      checks++; if (shift_en !== 1'b1) begin errors++; $display("FAIL single_shift_en got=%b exp=1", shift_en); end
      cyc();
      bit_tick = 1'b0;
    end
    checks++; if (capture_en !== 1'b1) begin errors++; $display("FAIL single_capture got=%b exp=1", capture_en); end
    cyc();
    checks++; if ({spif, ss_n_out, idle, capture_en} !== 4'b1110) begin errors++; $display("FAIL single_done got=%b exp=1110", {spif, ss_n_out, idle, capture_en}); end
    checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL single_cap_cnt got=%0d exp=1", cap_cnt); end
  endtask

  task automatic test_burst();
    pulse_clr();
    burst_len = 3'd3;
    cap_cnt = 0;
    ss_hi = 0;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) tx_wr = 1'b1;
      cyc();
      tx_wr = 1'b0;
      cyc();
      for (int t = 0; t < 8; t++) tick((t == 4) && (f < 2));
    end
    checks++; if (cap_cnt !== 3) begin errors++; $display("FAIL burst_cap_cnt got=%0d exp=3", cap_cnt); end
    checks++; if (ss_hi !== 0) begin errors++; $display("FAIL burst_ss_held got=%0d exp=0", ss_hi); end
    cyc();
    checks++; if ({ss_n_out, idle, spif} !== 3'b111) begin errors++; $display("FAIL burst_end got=%b exp=111", {ss_n_out, idle, spif}); end
  endtask

  task automatic test_hold();
    pulse_clr();
    burst_len = 3'd2;
    cap_cnt = 0;
    ss_hi = 0;
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    cyc();
    for (int t = 0; t < 8; t++) tick(1'b0);
    repeat (50) cyc();
    checks++; if ({state_dbg, ss_n_out} !== {S_UPD, 1'b0}) begin errors++; $display("FAIL hold_state got=%b exp=%b", {state_dbg, ss_n_out}, {S_UPD, 1'b0}); end
    checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL hold_cap_cnt got=%0d exp=1", cap_cnt); end
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL hold_reload got=%b exp=1", load_en); end
    cyc();
    for (int t = 0; t < 8; t++) tick(1'b0);
    cyc();
    checks++; if (cap_cnt !== 2) begin errors++; $display("FAIL hold_cap_cnt2 got=%0d exp=2", cap_cnt); end
    checks++; if ({ss_n_out, idle, ss_hi} !== {1'b1, 1'b1, 32'd1}) begin errors++; $display("FAIL hold_end got=%b/%b/%0d exp=1/1/1", ss_n_out, idle, ss_hi); end
  endtask

  task automatic test_wcol();
    burst_len = 3'd0;
    pulse_clr();
    checks++; if ({spif, wcol} !== 2'b00) begin errors++; $display("FAIL wcol_cleared got=%b exp=00", {spif, wcol}); end
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    cyc();
    for (int t = 0; t < 8; t++) tick(t == 4);
    checks++; if ({capture_en, wcol} !== 2'b11) begin errors++; $display("FAIL wcol_set got=%b exp=11", {capture_en, wcol}); end
    spif_clr = 1'b1;
    cyc();
    spif_clr = 1'b0;
    checks++; if ({spif, wcol} !== 2'b10) begin errors++; $display("FAIL wcol_clr_race got=%b exp=10", {spif, wcol}); end
    checks++; if ({ss_n_out, state_dbg} !== {1'b1, S_IDLE}) begin errors++; $display("FAIL wcol_len0_end got=%b exp=%b", {ss_n_out, state_dbg}, {1'b1, S_IDLE}); end
  endtask

  task automatic test_abort();
    burst_len = 3'd1;
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    cyc();
    tick(1'b0);
    tick(1'b0);
    checks++; if (bit_cnt !== 3'd2) begin errors++; $display("FAIL abort_bit_cnt got=%0d exp=2", bit_cnt); end
    spe = 1'b0;
    cyc();
    checks++; if ({state_dbg, ss_n_out, bit_cnt} !== {S_OFF, 1'b1, 3'd0}) begin errors++; $display("FAIL spe_off got=%b exp=%b", {state_dbg, ss_n_out, bit_cnt}, {S_OFF, 1'b1, 3'd0}); end
    checks++; if ({spif, brg_clr} !== 2'b11) begin errors++; $display("FAIL spe_off_flags got=%b exp=11", {spif, brg_clr}); end
    spe = 1'b1;
    cyc();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL spe_on got=%0d exp=%0d", state_dbg, S_IDLE); end
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    cyc();
    tick(1'b0);
    mstr = 1'b0;
    cyc();
    checks++; if ({state_dbg, ss_n_out} !== {S_OFF, 1'b1}) begin errors++; $display("FAIL mstr_abort got=%b exp=%b", {state_dbg, ss_n_out}, {S_OFF, 1'b1}); end
    mstr = 1'b1;
    cyc();
  endtask

  task automatic test_slave();
    mstr = 1'b0;
    ss_n_in = 1'b1;
    pulse_clr();
    cap_cnt = 0;
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL slave_wait_ss got=%0d exp=%0d", state_dbg, S_IDLE); end
    ss_n_in = 1'b0;
    cyc();
    checks++; if ({load_en, ss_n_out} !== 2'b11) begin errors++; $display("FAIL slave_load got=%b exp=11", {load_en, ss_n_out}); end
    cyc();
    for (int t = 0; t < 3; t++) tick(1'b0);
    checks++; if (bit_cnt !== 3'd3) begin errors++; $display("FAIL slave_bit_cnt got=%0d exp=3", bit_cnt); end
    ss_n_in = 1'b1;
    cyc();
    checks++; if ({state_dbg, idle, bit_cnt} !== {S_IDLE, 1'b1, 3'd0}) begin errors++; $display("FAIL slave_abort got=%b exp=%b", {state_dbg, idle, bit_cnt}, {S_IDLE, 1'b1, 3'd0}); end
    repeat (3) cyc();
    checks++; if ({spif, cap_cnt} !== {1'b0, 32'd0}) begin errors++; $display("FAIL slave_no_capture got=%b/%0d exp=0/0", spif, cap_cnt); end
  endtask

  task automatic test_reset_mid();
    ss_n_in = 1'b0;
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    cyc();
    cyc();
    tick(1'b0);
    tick(1'b1);
    checks++; if ({state_dbg, wcol, bit_cnt} !== {S_RUN, 1'b1, 3'd2}) begin errors++; $display("FAIL mid_pre got=%b exp=%b", {state_dbg, wcol, bit_cnt}, {S_RUN, 1'b1, 3'd2}); end
    rst = 1'b0;
    bit_tick = 1'b1;
    #1;
    checks++; if ({state_dbg, ss_n_out, idle, bit_cnt} !== {S_OFF, 1'b1, 1'b1, 3'd0}) begin errors++; $display("FAIL mid_reset_state got=%b exp=%b", {state_dbg, ss_n_out, idle, bit_cnt}, {S_OFF, 1'b1, 1'b1, 3'd0}); end
    checks++; if ({spif, wcol, load_en, shift_en, capture_en} !== 5'b0) begin errors++; $display("FAIL mid_reset_outs got=%b exp=00000", {spif, wcol, load_en, shift_en, capture_en}); end
    bit_tick = 1'b0;
    cyc();
    rst = 1'b1; mstr = 1'b1; ss_n_in = 1'b1; spe = 1'b1;
    cyc();
  endtask

`ifdef SPI_MODF_DETECT_EN
  task automatic test_modf();
    burst_len = 3'd1;
    cap_cnt = 0;
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    cyc();
    tick(1'b0);
    ss_n_in = 1'b0;
    cyc();
    ss_n_in = 1'b1;
    checks++; if ({modf, state_dbg, ss_n_out, brg_clr} !== {1'b1, S_OFF, 1'b1, 1'b1}) begin errors++; $display("FAIL modf_set got=%b exp=%b", {modf, state_dbg, ss_n_out, brg_clr}, {1'b1, S_OFF, 1'b1, 1'b1}); end
    repeat (3) cyc();
    checks++; if (state_dbg !== S_OFF) begin errors++; $display("FAIL modf_hold got=%0d exp=%0d", state_dbg, S_OFF); end
    pulse_clr();
    checks++; if (modf !== 1'b0) begin errors++; $display("FAIL modf_clr got=%b exp=0", modf); end
    cyc();
    tx_wr = 1'b1;
    cyc();
    tx_wr = 1'b0;
    checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL modf_restart got=%b exp=1", load_en); end
    cyc();
    for (int t = 0; t < 8; t++) tick(1'b0);
    checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL modf_frame got=%0d exp=1", cap_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_hold();
    test_wcol();
    test_abort();
    test_slave();
    test_reset_mid();
`ifdef SPI_MODF_DETECT_EN
    test_modf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
